// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined AES/Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns.
// Defining SHIFT_ROWS_PIPE_BYPASS_EN adds the Bypass_in / Bypass_out identity sideband.
module shift_rows_pipe #(
    parameter int NB         = 4,
    parameter int PIPE_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic             Mode_in,
    input  logic [0:32*NB-1] Data_in,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    input  logic             Bypass_in,
    output logic             Bypass_out,
`endif
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [0:32*NB-1] Data_out,
    output logic             Mode_out
);
    localparam int W  = 32 * NB;
    localparam int S2 = (NB == 8) ? 3 : 2;
    localparam int S3 = (NB == 8) ? 4 : 3;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    localparam int TW = 2;
`else
    localparam int TW = 1;
`endif

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
            $error("shift_rows_pipe: PIPE_DEPTH must be 1..4");
        end
    endgenerate

    logic [0:W-1]  fwd_perm;
    logic [0:W-1]  inv_perm;
    logic [0:W-1]  perm_data;
    logic [TW-1:0] tag_in;

    genvar gi;
    // Byte k sits at row k%4, column k/4; each output byte is a fixed wire from one input byte.
    for (gi = 0; gi < 4 * NB; gi++) begin : g_byte
        localparam int R  = gi % 4;
        localparam int C  = gi / 4;
        localparam int S  = (R == 0) ? 0 : (R == 1) ? 1 : (R == 2) ? S2 : S3;
        localparam int CF = (C + S) % NB;
        localparam int CI = (C - S + NB) % NB;
        assign fwd_perm[8*gi +: 8] = Data_in[8*(4*CF+R) +: 8];
        assign inv_perm[8*gi +: 8] = Data_in[8*(4*CI+R) +: 8];
    end

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign perm_data = Bypass_in ? Data_in : (Mode_in ? inv_perm : fwd_perm);
    assign tag_in    = {Bypass_in, Mode_in};
`else
    assign perm_data = Mode_in ? inv_perm : fwd_perm;
    assign tag_in    = Mode_in;
`endif

    logic [PIPE_DEPTH-1:0] v_q;
    logic [PIPE_DEPTH-1:0] v_d;
    logic [PIPE_DEPTH-1:0] src_v;
    logic [PIPE_DEPTH-1:0] rdy;
    logic [0:W-1]          d_q   [PIPE_DEPTH];
    logic [0:W-1]          d_d   [PIPE_DEPTH];
    logic [0:W-1]          src_d [PIPE_DEPTH];
    logic [TW-1:0]         t_q   [PIPE_DEPTH];
    logic [TW-1:0]         t_d   [PIPE_DEPTH];
    logic [TW-1:0]         src_t [PIPE_DEPTH];

    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
        // Flattened form of rdy_i = !v_i || rdy_(i+1): any bubble downstream lets this stage move.
        assign rdy[gi] = Out_ready || !(&v_q[PIPE_DEPTH-1:gi]);
        if (gi == 0) begin : g_head
            assign src_v[gi] = In_valid;
            assign src_d[gi] = perm_data;
            assign src_t[gi] = tag_in;
        end else begin : g_tail
            assign src_v[gi] = v_q[gi-1];
            assign src_d[gi] = d_q[gi-1];
            assign src_t[gi] = t_q[gi-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        t_d = t_q;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (rdy[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    d_d[i] = src_d[i];
                    t_d[i] = src_t[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                d_q[i] <= '0;
                t_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
            t_q <= t_d;
        end
    end

    assign In_ready  = rdy[0];
    assign Out_valid = v_q[PIPE_DEPTH-1];
    assign Data_out  = d_q[PIPE_DEPTH-1];
    assign Mode_out  = t_q[PIPE_DEPTH-1][0];
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign Bypass_out = t_q[PIPE_DEPTH-1][1];
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: random and directed checks of shift_rows_pipe for NB 4/6/8 against a row-rotation model.
// Instance under test is chosen by sel; sel 2 is an NB=8 forward/inverse chain.
module tb_shift_rows_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    int first_acc = -1;
    int first_ov = -1;
    int last_ov = -1;
    int stall_pct = 0;

    logic [1:0]   sel = 2'd0;
    logic         tb_valid = 1'b0;
    logic         tb_mode = 1'b0;
    logic         tb_ready = 1'b1;
    logic [0:255] tb_data = '0;

    typedef struct {
        logic [0:255] d;
        logic         m;
    } exp_t;
    exp_t q_exp[$];
    exp_t q_c[$];

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    logic [4:0] byp_o;
`define TB_BYP(n) .Bypass_in(1'b0), .Bypass_out(byp_o[n]),
`else
`define TB_BYP(n)
`endif

    logic a_irdy, a_ov, a_mo, b_irdy, b_ov, b_mo, c_irdy, c_ov, c_mo;
    logic r_irdy, r_ov, r_mo, d_irdy, d_ov, d_mo;
    logic [0:127] a_do, d_do;
    logic [0:191] b_do;
    logic [0:255] c_do, r_do;

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .In_valid(tb_valid && sel == 2'd0), .In_ready(a_irdy),
        .Mode_in(tb_mode), .Data_in(tb_data[0:127]), `TB_BYP(0)
        .Out_valid(a_ov), .Out_ready(tb_ready), .Data_out(a_do), .Mode_out(a_mo));
    shift_rows_pipe #(.NB(6), .PIPE_DEPTH(1)) u_b (
        .clk(clk), .rst_n(rst_n), .In_valid(tb_valid && sel == 2'd1), .In_ready(b_irdy),
        .Mode_in(tb_mode), .Data_in(tb_data[0:191]), `TB_BYP(1)
        .Out_valid(b_ov), .Out_ready(tb_ready), .Data_out(b_do), .Mode_out(b_mo));
    shift_rows_pipe #(.NB(8), .PIPE_DEPTH(3)) u_c (
        .clk(clk), .rst_n(rst_n), .In_valid(tb_valid && sel == 2'd2), .In_ready(c_irdy),
        .Mode_in(tb_mode), .Data_in(tb_data), `TB_BYP(2)
        .Out_valid(c_ov), .Out_ready(r_irdy), .Data_out(c_do), .Mode_out(c_mo));
    shift_rows_pipe #(.NB(8), .PIPE_DEPTH(1)) u_r (
        .clk(clk), .rst_n(rst_n), .In_valid(c_ov), .In_ready(r_irdy),
        .Mode_in(~c_mo), .Data_in(c_do), `TB_BYP(3)
        .Out_valid(r_ov), .Out_ready(tb_ready), .Data_out(r_do), .Mode_out(r_mo));
    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(3)) u_d (
        .clk(clk), .rst_n(rst_n), .In_valid(tb_valid && sel == 2'd3), .In_ready(d_irdy),
        .Mode_in(tb_mode), .Data_in(tb_data[0:127]), `TB_BYP(4)
        .Out_valid(d_ov), .Out_ready(tb_ready), .Data_out(d_do), .Mode_out(d_mo));

    logic         cur_irdy, cur_ov, cur_mo;
    logic [0:255] cur_do;
    always_comb begin
        cur_irdy = 1'b0;
        cur_ov   = 1'b0;
        cur_mo   = 1'b0;
        cur_do   = '0;
        case (sel)
            2'd0: begin cur_irdy = a_irdy; cur_ov = a_ov; cur_mo = a_mo; cur_do[0:127] = a_do; end
            2'd1: begin cur_irdy = b_irdy; cur_ov = b_ov; cur_mo = b_mo; cur_do[0:191] = b_do; end
            2'd2: begin cur_irdy = c_irdy; cur_ov = r_ov; cur_mo = r_mo; cur_do = r_do; end
            default: begin cur_irdy = d_irdy; cur_ov = d_ov; cur_mo = d_mo; cur_do[0:127] = d_do; end
        endcase
    end

    // Row r rotates left by s(r) columns (forward) or right (inverse).
    function automatic logic [0:255] srow(input int nb, input logic inv, input logic [0:255] x);
        logic [0:255] y;
        int r, c, s, sc;
        y = '0;
        for (int k = 0; k < 4 * nb; k++) begin
            r = k % 4;
            c = k / 4;
            case (r)
                0: s = 0;
                1: s = 1;
                2: s = (nb == 8) ? 3 : 2;
                default: s = (nb == 8) ? 4 : 3;
            endcase
            sc = inv ? (c - s + nb) % nb : (c + s) % nb;
            y[8*k +: 8] = x[8*(4*sc+r) +: 8];
        end
        return y;
    endfunction

    function automatic int nb_of(input logic [1:0] s);
        return (s == 2'd1) ? 6 : (s == 2'd2) ? 8 : 4;
    endfunction

    function automatic logic [0:255] rand256();
        logic [0:255] x;
        for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
        return x;
    endfunction

    task automatic chk(input string name, input logic [0:255] act, input logic [0:255] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic monitor();
        logic         prev_stall;
        logic [0:255] prev_do;
        logic         prev_mo;
        exp_t         e;
        prev_stall = 1'b0;
        prev_do = '0;
        prev_mo = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (tb_valid && cur_irdy) begin
                if (sel == 2'd2) begin
                    q_exp.push_back('{d: tb_data, m: ~tb_mode});
                    q_c.push_back('{d: srow(8, tb_mode, tb_data), m: tb_mode});
                end else begin
                    q_exp.push_back('{d: srow(nb_of(sel), tb_mode, tb_data), m: tb_mode});
                end
                if (first_acc < 0) first_acc = cyc + 1;
            end
            if (prev_stall) begin
                chk("stall_valid", {255'b0, cur_ov}, {255'b0, 1'b1});
                chk("stall_data", cur_do, prev_do);
                chk("stall_mode", {255'b0, cur_mo}, {255'b0, prev_mo});
            end
            if (cur_ov && tb_ready) begin
                out_count++;
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing outstanding", cur_do);
                end else begin
                    e = q_exp.pop_front();
                    chk("out_data", cur_do, e.d);
                    chk("out_mode", {255'b0, cur_mo}, {255'b0, e.m});
                end
            end
            if (sel == 2'd2 && c_ov && r_irdy) begin
                if (q_c.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_nb8_output: got %h", c_do);
                end else begin
                    e = q_c.pop_front();
                    chk("nb8_fwd_data", c_do, e.d);
                    chk("nb8_fwd_mode", {255'b0, c_mo}, {255'b0, e.m});
                end
            end
            prev_stall = cur_ov && !tb_ready;
            prev_do = cur_do;
            prev_mo = cur_mo;
        end
    endtask

    task automatic push_item(input logic [0:255] d, input logic m);
        bit acc;
        acc = 1'b0;
        tb_valid = 1'b1;
        tb_data = d;
        tb_mode = m;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = cur_irdy;
            @(posedge clk);
            #1;
            tb_ready = ($urandom_range(99) >= stall_pct);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no In_ready within 200 cycles expected acceptance");
        end
        tb_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        tb_valid = 1'b0;
        stall_pct = 0;
        tb_ready = 1'b1;
        t = 0;
        while ((q_exp.size() != 0 || q_c.size() != 0 || cur_ov) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_outstanding", 256'(q_exp.size() + q_c.size()), 256'd0);
    endtask

    task automatic run_random(input int n, input int stall, input int idle);
        stall_pct = stall;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < idle) begin
                tb_valid = 1'b0;
                tb_ready = ($urandom_range(99) >= stall_pct);
                @(posedge clk);
                #1;
            end
            push_item(rand256(), 1'($urandom_range(1)));
        end
        drain();
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cur_ov && n < 20);
    endtask

    initial begin
        logic [0:255] x, y, t, fwd_lit, inv_lit;
        int n, cnt0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("reset_valid", {255'b0, cur_ov}, 256'd0);
            chk("reset_data", cur_do, 256'd0);
            chk("reset_mode", {255'b0, cur_mo}, 256'd0);
            chk("reset_in_ready", {255'b0, cur_irdy}, {255'b0, 1'b1});
        end
        sel = 2'd0;
        @(posedge clk);
        #1;

        // Model pins from hand-computed vectors.
        x = '0;
        x[0:127] = 128'h00112233445566778899aabbccddeeff;
        fwd_lit = '0;
        fwd_lit[0:127] = 128'h0055aaff4499ee3388dd2277cc1166bb;
        inv_lit = '0;
        inv_lit[0:127] = 128'h00ddaa774411eebb885522ffcc996633;
        chk("pin_fwd4", srow(4, 1'b0, x), fwd_lit);
        chk("pin_inv4", srow(4, 1'b1, x), inv_lit);
        for (int k = 0; k < 32; k++) y[8*k +: 8] = 8'(k);
        t = srow(8, 1'b0, y);
        chk("pin_nb8_byte2", {248'b0, t[16 +: 8]}, {248'b0, 8'd14});
        for (int nb = 4; nb <= 8; nb += 2) begin
            y = rand256();
            for (int k = 4 * nb; k < 32; k++) y[8*k +: 8] = 8'h00;
            chk("pin_roundtrip", srow(nb, 1'b1, srow(nb, 1'b0, y)), y);
        end

        // Literal vectors through NB=4, depth 2.
        push_item(x, 1'b0);
        wait_out(n);
        chk("t1_latency", 256'(n), 256'd2);
        chk("t1_data", cur_do, fwd_lit);
        chk("t1_mode", {255'b0, cur_mo}, 256'd0);
        @(posedge clk);
        #1;
        push_item(x, 1'b1);
        wait_out(n);
        chk("t2_data", cur_do, inv_lit);
        chk("t2_mode", {255'b0, cur_mo}, {255'b0, 1'b1});
        drain();

        // 20 back-to-back alternating transactions, NB=4, depth 3.
        sel = 2'd3;
        first_acc = -1;
        first_ov = -1;
        cnt0 = out_count;
        for (int i = 0; i < 20; i++) push_item(rand256(), 1'(i % 2));
        drain();
        chk("t3_latency", 256'(first_ov - first_acc), 256'd2);
        chk("t3_consecutive", 256'(last_ov - first_ov), 256'd19);
        chk("t3_count", 256'(out_count - cnt0), 256'd20);
        run_random(40, 30, 20);

        // Backpressure with both stages full, NB=4, depth 2.
        sel = 2'd0;
        cnt0 = out_count;
        stall_pct = 100;
        tb_ready = 1'b0;
        push_item(rand256(), 1'b0);
        push_item(rand256(), 1'b1);
        tb_valid = 1'b1;
        tb_data = rand256();
        tb_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_in_ready", {255'b0, cur_irdy}, 256'd0);
            chk("t4_out_valid", {255'b0, cur_ov}, {255'b0, 1'b1});
            @(posedge clk);
            #1;
        end
        stall_pct = 0;
        tb_ready = 1'b1;
        push_item(tb_data, tb_mode);
        drain();
        chk("t4_count", 256'(out_count - cnt0), 256'd3);
        run_random(60, 40, 20);

        sel = 2'd1;
        run_random(60, 30, 20);
        sel = 2'd2;
        run_random(60, 30, 20);

        // Asynchronous reset with two items in flight.
        sel = 2'd0;
        stall_pct = 100;
        tb_ready = 1'b0;
        push_item(rand256() | 256'h1, 1'b1);
        push_item(rand256() | 256'h1, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid_async", {255'b0, a_ov}, 256'd0);
        chk("t6_data_async", {128'b0, a_do}, 256'd0);
        chk("t6_mode_async", {255'b0, a_mo}, 256'd0);
        q_exp.delete();
        q_c.delete();
        stall_pct = 0;
        tb_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", {255'b0, cur_irdy}, {255'b0, 1'b1});
        chk("t6_valid_after", {255'b0, cur_ov}, 256'd0);
        @(posedge clk);
        #1;
        cnt0 = out_count;
        push_item(rand256(), 1'b0);
        drain();
        chk("t6_single_output", 256'(out_count - cnt0), 256'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined ShiftRows / InvShiftRows unit for the AES/Rijndael datapath; successor to the fixed 128-bit combinational inverse-shift block. Supports Rijndael block widths of 4, 6 or 8 columns. Direction is selected per transaction, and a valid/ready pipeline provides full throughput. Sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns in the round datapath.

Parameters:
NB, 4, state columns; legal 4, 6, 8; data width W = 32*NB
PIPE_DEPTH, 1, register stages; legal 1..4
(illegal NB or PIPE_DEPTH -> elaboration-time $error)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
In_valid  input  1  upstream transaction valid
In_ready  output  1  block can accept this cycle
Mode_in  input  1  0 = forward ShiftRows, 1 = InvShiftRows
Data_in  input  [0:W-1]  state in; byte k = Data_in[8k+:8], row r = k%4, column c = k/4
Out_valid  output  1  Data_out valid
Out_ready  input  1  downstream accepts
Data_out  output  [0:W-1]  shifted state, same byte layout
Mode_out  output  1  Mode_in of the transaction on Data_out

Behaviour:
- Clocking: one clock (clk); rst_n is asynchronous, active-low.
- Row shift amounts: s(0)=0. s(1)=1. s(2)=2 for NB=4/6, 3 for NB=8. s(3)=3 for NB=4/6, 4 for NB=8.
- Forward mapping: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse mapping: out[r][c] = in[r][(c - s(r)) mod NB]; inverse(forward(x)) == x for every NB.
- Permutation is combinational on Data_in and selected by Mode_in. The result is captured in stage 0; stages 1..PIPE_DEPTH-1 are plain data-plus-mode registers.
- Each stage i holds v_i, d_i, m_i. Last stage drives Out_valid/Data_out/Mode_out.
- Stage i is ready when: rdy_i = !v_i || rdy_(i+1), with rdy_PIPE_DEPTH = Out_ready. In_ready = rdy_0 (combinational path from Out_ready; no skid buffer).
- Stage i loads on rdy_i: v_i <= v_(i-1), with v_-1 = In_valid. d/m are loaded only when the incoming valid is 1; otherwise they hold.
- Latency: exactly PIPE_DEPTH cycles from an accepted input (In_valid & In_ready) to Out_valid, with no stalls.
- Throughput: one transaction per cycle while Out_ready = 1.
- Backpressure: with Out_valid=1 and Out_ready=0, Data_out/Mode_out stay stable. Bubbles collapse: In_ready=1 while any stage is empty.
- Simultaneous accept and emit on a full pipe: allowed; no loss and no duplication.
- Ordering: strict FIFO order; mixed forward/inverse transactions interleave freely.
- Reset (including mid-operation): all v_i=0, d_i=0, m_i=0. Out_valid=0, Data_out=0, Mode_out=0. In-flight data is discarded. In_ready=1 from the first cycle after deassertion.
- Data_in/Mode_in are don't-care when In_valid=0.

Optional Feature:
- Macro: SHIFT_ROWS_PIPE_BYPASS_EN.
- When defined, adds input Bypass_in (1 bit, sampled with Mode_in) and output Bypass_out.
  - Bypass_in=1: the transaction passes unpermuted (out = in) with the same latency and handshake.
  - Bypass_out reports the flag alongside Data_out; it resets to 0.
  - Used for the final-round/identity path and for debug.
- When undefined, these ports do not exist and every transaction is permuted per Mode_in.

Test Plan:
1. NB=4, PIPE_DEPTH=1, Mode_in=0, Data_in=00112233445566778899aabbccddeeff -> one cycle later Out_valid=1, Data_out=0055aaff4499ee3388dd2277cc1166bb, Mode_out=0.
2. NB=4, same Data_in, Mode_in=1 -> Data_out=00ddaa774411eebb885522ffcc996633, Mode_out=1.
3. NB=4, PIPE_DEPTH=3, 20 back-to-back transactions alternating mode, Out_ready=1 -> first Out_valid on cycle 3 after the first accept. All 20 results emerge in order on consecutive cycles, each matching the reference model.
4. PIPE_DEPTH=2, Out_ready held 0 for 5 cycles after pipe fills -> In_ready=0 once both stages are valid; Data_out stable. On Out_ready=1 the queued items drain in order with no drop or duplicate.
5. NB=8 and NB=6, random data: forward then inverse through two instances -> output equals the original. For NB=8, byte k=2 (r2,c0) forward comes from input byte 14 (r2,c3).
6. rst_n asserted asynchronously mid-stream with 2 items in flight (PIPE_DEPTH=2) -> Out_valid=0 immediately with no clock edge, Data_out=0. After release, the first new input produces exactly one output and no stale data appears.
